fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the 32-entry FIFO between NREQ producers.

---
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-locked arbiter for the shared FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DBits     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DBits-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DBits-1:0]      fifo_wr_data,
    output logic                  busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]       state;
    logic [OW-1:0]    last;
    logic [CW-1:0]    beat_cnt;

    logic [OW-1:0]    pick;
    logic             pick_valid;
    logic             owner_req;
    logic [DBits-1:0] owner_data;
    logic             wr;
    logic             last_beat;

    // Search starts just after the previous owner so every active lane is served in turn.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NREQ;
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick       = OW'(idx);
            end
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == OW'(i)) begin
                owner_req  = req[i];
                owner_data = req_data[i*DBits +: DBits];
            end
        end
    end

    assign wr        = (state == ST_BURST) && owner_req && !fifo_full;
    assign last_beat = (beat_cnt == CW'(MAX_BURST - 1));

    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = wr && (owner == OW'(i));
        end
    end

    assign fifo_wr_en   = wr;
    assign fifo_wr_data = wr ? owner_data : '0;
    assign busy         = (state == ST_BURST);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            last     <= OW'(NREQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (wr) begin
                        if (last_beat) begin
                            state <= ST_IDLE;
                            last  <= owner;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (!owner_req) begin
                        state <= ST_IDLE;
                        last  <= owner;
                    end
                    // owner_req with fifo_full: hold everything until space appears
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a 32-entry FIFO model
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DB   = 8;
    localparam int MB   = 4;

    logic              clk = 1'b0;
    logic              areset;
    logic [NREQ-1:0]   req;
    logic [NREQ*DB-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DB-1:0]     fifo_wr_data;
    logic              busy;
    logic [1:0]        owner;

    fifo_wr_arbiter #(.NREQ(NREQ), .DBits(DB), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .areset       (areset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lane;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fq[$];
    int         rem[NREQ];
    int         seq[NREQ];
    bit         const_mode;
    bit         fill_mode;
    bit         drain;
    int         wr_cycles;
    int         busy_cycles;
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ldata(input int l, input int s);
        logic [7:0] base;
        logic [1:0] lb;
        logic [5:0] sb6;
        base = 8'hA0;
        lb   = 2'(l);
        sb6  = 6'(s);
        return const_mode ? (base + 8'(l)) : {lb, sb6};
    endfunction

    task automatic expect_beat(input int l, input int s);
        exp_t e;
        e.lane = l;
        e.data = ldata(l, s);
        sb.push_back(e);
    endtask

    task automatic update_inputs();
        for (int l = 0; l < NREQ; l++) begin
            req[l]               = (rem[l] > 0);
            req_data[l*DB +: DB] = ldata(l, seq[l]);
        end
        fifo_full = fill_mode && (fq.size() >= 31);
    endtask

    task automatic step();
        logic [NREQ-1:0] got_ack;
        exp_t            e;
        @(negedge clk);
        if (busy) busy_cycles++;
        got_ack = ack;
        if (fifo_wr_en) begin
            wr_cycles++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(fifo_wr_data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_data", 32'(fifo_wr_data), 32'(e.data));
                chk("ack_lane", 32'(ack), 32'(1) << e.lane);
            end
            fq.push_back(fifo_wr_data);
        end else if (ack != '0) begin
            chk("ack_without_wr", 32'(ack), 32'h0);
        end
        @(posedge clk);
        #1;
        if (drain && fq.size() > 0) void'(fq.pop_front());
        for (int l = 0; l < NREQ; l++) begin
            if (got_ack[l]) begin
                rem[l]--;
                seq[l]++;
            end
        end
        update_inputs();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        for (int l = 0; l < NREQ; l++) begin
            rem[l] = 0;
            seq[l] = 0;
        end
        sb.delete();
        fq.delete();
        const_mode  = 1'b0;
        fill_mode   = 1'b0;
        drain       = 1'b0;
        wr_cycles   = 0;
        busy_cycles = 0;
        update_inputs();
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        int w0;
        int b0;
        areset = 1'b1;
        req = '0;
        req_data = '0;
        fifo_full = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_wr_data", 32'(fifo_wr_data), 0);

        // mid-burst asynchronous reset, then first grant to lane 0
        do_reset();
        for (int l = 0; l < NREQ; l++) rem[l] = 8;
        for (int b = 0; b < MB; b++) expect_beat(0, b);
        expect_beat(1, 0);
        update_inputs();
        repeat (7) step();
        chk("t1_pre_busy", 32'(busy), 1);
        #1;
        areset = 1'b1;
        #1;
        chk("t1_async_busy", 32'(busy), 0);
        chk("t1_async_ack", 32'(ack), 0);
        chk("t1_async_wr_en", 32'(fifo_wr_en), 0);
        do_reset();
        rem[0] = 1;
        rem[1] = 1;
        expect_beat(0, 0);
        expect_beat(1, 0);
        update_inputs();
        step();
        chk("t1_first_owner", 32'(owner), 0);
        repeat (6) step();
        chk("t1_sb_empty", 32'(sb.size()), 0);

        // round robin with all four lanes held
        do_reset();
        for (int l = 0; l < NREQ; l++) rem[l] = 8;
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < NREQ; l++)
                for (int b = 0; b < MB; b++) expect_beat(l, r*MB + b);
        update_inputs();
        repeat (40) step();
        chk("t2_sb_empty", 32'(sb.size()), 0);
        chk("t2_writes", 32'(wr_cycles), 32);
        chk("t2_busy_cycles", 32'(busy_cycles), 32);
        chk("t2_idle_after", 32'(busy), 0);
        for (int l = 0; l < NREQ; l++) chk("t2_lane_drained", 32'(rem[l]), 0);

        // early release of lane 2, then fairness skips back to lane 0
        do_reset();
        rem[2] = 2;
        expect_beat(2, 0);
        expect_beat(2, 1);
        update_inputs();
        repeat (4) step();
        chk("t3_busy", 32'(busy), 0);
        chk("t3_owner_held", 32'(owner), 2);
        chk("t3_writes", 32'(wr_cycles), 2);
        rem[0] = 1;
        rem[2] = 1;
        expect_beat(0, 0);
        expect_beat(2, 2);
        update_inputs();
        step();
        chk("t3_next_owner", 32'(owner), 0);
        repeat (6) step();
        chk("t3_sb_empty", 32'(sb.size()), 0);

        // full stall on lane 1, then drain and resume
        do_reset();
        fill_mode = 1'b1;
        rem[1] = 40;
        for (int s = 0; s < 40; s++) expect_beat(1, s);
        update_inputs();
        for (int c = 0; c < 100 && !fifo_full; c++) step();
        chk("t4_full_reached", 32'(fifo_full), 1);
        chk("t4_writes_at_full", 32'(wr_cycles), 31);
        w0 = wr_cycles;
        b0 = busy_cycles;
        repeat (10) step();
        chk("t4_stall_writes", 32'(wr_cycles - w0), 0);
        chk("t4_stall_busy", 32'(busy_cycles - b0), 10);
        drain = 1'b1;
        for (int c = 0; c < 100 && rem[1] > 0; c++) step();
        chk("t4_lane_drained", 32'(rem[1]), 0);
        chk("t4_total_writes", 32'(wr_cycles), 40);
        chk("t4_sb_empty", 32'(sb.size()), 0);

        // data path: constant lane data, readout order follows grants
        do_reset();
        const_mode = 1'b1;
        for (int l = 0; l < NREQ; l++) begin
            rem[l] = 2;
            expect_beat(l, 0);
            expect_beat(l, 1);
        end
        update_inputs();
        repeat (20) step();
        chk("t5_sb_empty", 32'(sb.size()), 0);
        chk("t5_fifo_count", 32'(fq.size()), 8);
        for (int i = 0; i < 8 && i < fq.size(); i++)
            chk("t5_readout", 32'(fq[i]), 32'(8'hA0 + 8'(i / 2)));

        // idle for 100 cycles
        do_reset();
        repeat (100) step();
        chk("t6_no_writes", 32'(wr_cycles), 0);
        chk("t6_never_busy", 32'(busy_cycles), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
